i2c_sensor_poller: RTL and testbench
====================================

# i2c_sensor_poller

Parametrised sensor polling sequencer for the I2C path. After `enable` rises it runs a configurable table of register writes to initialise the sensors. It then reads N_CH 16-bit channels every PERIOD cycles, retrying NACKed transfers, and publishes each completed round as one atomic snapshot. It sits between the host/PC register block and the byte-level I2C transaction engine, and replaces the fixed accelerometer/magnetometer sequencing.

## Interface
- `N_CH`, 6, number of 16-bit channels read per round (1..16)
- `N_INIT`, 2, number of init writes (1..8)
- `INIT_TABLE`, {8'h3C,8'h02,8'h00, 8'h32,8'h20,8'h37}, N_INIT*24 bits; entry i = bits [24*i +: 24] = {slave, reg, value}; entry 0 is the LSBs
- `CH_TABLE`, {3C/05,3C/07,3C/03,32/AC,32/AA,32/A8}, N_CH*16 bits; entry i = bits [16*i +: 16] = {slave, reg}; channel 0 is X-accel (32/A8)
- `CH_BE`, 6'b111000, bit i=1: channel i is big-endian (first byte is MSB); 0: little-endian
- `PERIOD`, 100000, round start interval in clk cycles (>= 2)
- `MAX_RETRY`, 3, retries per transaction after the first NACK
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `enable`  in  1  run request; level-sensitive
- `txn_valid`  out  1  transaction request to the I2C engine
- `txn_ready`  in  1  engine accepts the request when high with `txn_valid`
- `txn_rw`  out  1  0 = single-byte write, 1 = two-byte read
- `txn_slave`  out  8  slave address in 8-bit write form (e.g. 8'h32); the engine sets the R/W bit
- `txn_reg`  out  8  register address
- `txn_wdata`  out  8  write value (don't-care on reads)
- `rd_valid`  in  1  one received byte per pulse
- `rd_data`  in  8  received byte
- `txn_done`  in  1  one-cycle pulse ending the accepted transaction
- `txn_nack`  in  1  qualified by `txn_done`; 1 = NACK or bus error
- `ch_data`  out  N_CH*16  snapshot; channel i = [16*i +: 16]
- `sample_valid`  out  1  one-cycle pulse when `ch_data` updates
- `sample_count`  out  16  completed rounds; wraps at 16'hFFFF -> 0
- `busy`  out  1  high in any state other than IDLE
- `overrun`  out  1  sticky; a round took longer than PERIOD
- `fault`  out  1  sticky; retries were exhausted

## Operation
- States: IDLE, INIT_REQ, INIT_WAIT, WAIT_PERIOD, RD_REQ, RD_WAIT, PUBLISH, FAULT.
- IDLE: when `enable`=1, clear the index and retry count and go to INIT_REQ.
- INIT_REQ: drive init entry idx with `txn_rw`=0. On accept, go to INIT_WAIT.
- INIT_WAIT, on `txn_done`:
  - `txn_nack`=0: idx++. After the last entry, idx=0 and go to RD_REQ (first round starts immediately). Otherwise return to INIT_REQ.
  - `txn_nack`=1: retry++ and re-issue the same entry. When retry would exceed MAX_RETRY, go to FAULT.
- RD_REQ / RD_WAIT: same handshake with `txn_rw`=1 and channel idx.
  - Capture the first and second `rd_valid` bytes into a 2-byte staging register; ignore further bytes.
  - `txn_done` with `txn_nack`=0 but fewer than 2 bytes received counts as a NACK.
  - On success, assemble the 16-bit value per CH_BE and store it in the shadow register idx. After the last channel go to PUBLISH.
- PUBLISH: copy shadow to `ch_data`, pulse `sample_valid`, increment `sample_count`, then go to WAIT_PERIOD.
- WAIT_PERIOD: the period counter counts from each round start (cycle RD_REQ is entered with idx=0). When it reaches PERIOD-1, reset it and go to RD_REQ. If it reaches PERIOD-1 before PUBLISH, set `overrun`; the next round starts directly after PUBLISH.
- The retry count resets on every successful transaction.
- `enable`=0:
  - In WAIT_PERIOD or a REQ state with no accept in that cycle: go to IDLE at once.
  - In a WAIT state: finish the outstanding transaction, then go to IDLE without publishing.
  - Re-enabling re-runs init.
- FAULT: `txn_valid`=0 and `fault`=1; left only by `rst`.

## Timing
- Reset values: `txn_valid`=0, `txn_rw`=0, `txn_slave`/`txn_reg`/`txn_wdata`=0, `ch_data`=0, `sample_valid`=0, `sample_count`=0, `busy`=0, `overrun`=0, `fault`=0; state IDLE.
- `rst` mid-transaction drops `txn_valid` at the same edge. `txn_done` pulses arriving afterwards are ignored in IDLE.
- All outputs are registered. `txn_valid` rises 1 cycle after entering a REQ state. Request fields are stable while `txn_valid`=1. `txn_valid` falls the cycle after accept.
- At most one outstanding transaction. `txn_done` pulses are ignored outside the WAIT states.
- `sample_valid` and the `ch_data` update occur in the same cycle, 1 cycle after the final `txn_done` of the round.
- `rd_valid` and `txn_done` may coincide: the byte is captured before completion is evaluated.

## Test plan
- Reset, enable, engine always ready and ACKs: two writes (32/20/37, 3C/02/00), then six reads in CH_TABLE order; bytes 8'h34,8'h12 on ch0 give ch_data[15:0]=16'h1234 and ch3 big-endian gives 16'h3412; `sample_valid` pulses once and `sample_count`=1.
- PERIOD=200, engine ACKs: `sample_valid` pulses exactly 200 cycles apart across 5 rounds; `overrun` stays 0.
- NACK the first 3 attempts of ch2, then ACK: exactly 4 requests for 32/AC, no fault, data correct. NACK 4 times: FAULT, `fault`=1, no further `txn_valid`.
- PERIOD=20 with a slow engine (round ~60 cycles): `overrun`=1, rounds run back-to-back, `sample_count` still increments by 1 per round.
- Drop `enable` in RD_WAIT of ch4: the outstanding read completes, no `sample_valid`, `busy`=0; re-enable: init writes reissued.
- Assert `rst` during INIT_WAIT: `txn_valid`=0 next cycle and all outputs at reset values; a late `txn_done` causes no state change.

Source files
------------

// File: rtl/i2c_sensor_poller.sv
// Sensor polling sequencer: runs an init write table once, then reads N_CH
// 16-bit channels every PERIOD cycles over a byte-level I2C engine.
module i2c_sensor_poller #(
    parameter int N_CH = 6,
    parameter int N_INIT = 2,
    parameter logic [N_INIT*24-1:0] INIT_TABLE = {8'h3C, 8'h02, 8'h00, 8'h32, 8'h20, 8'h37},
    parameter logic [N_CH*16-1:0] CH_TABLE = {16'h3C05, 16'h3C07, 16'h3C03, 16'h32AC, 16'h32AA, 16'h32A8},
    parameter logic [N_CH-1:0] CH_BE = 6'b111000,
    parameter int PERIOD = 100000,
    parameter int MAX_RETRY = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic               txn_valid,
    input  logic               txn_ready,
    output logic               txn_rw,
    output logic [7:0]         txn_slave,
    output logic [7:0]         txn_reg,
    output logic [7:0]         txn_wdata,
    input  logic               rd_valid,
    input  logic [7:0]         rd_data,
    input  logic               txn_done,
    input  logic               txn_nack,
    output logic [N_CH*16-1:0] ch_data,
    output logic               sample_valid,
    output logic [15:0]        sample_count,
    output logic               busy,
    output logic               overrun,
    output logic               fault
);
    localparam int IW = $clog2((N_CH > N_INIT ? N_CH : N_INIT) + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int PW = $clog2(PERIOD + 1);
    localparam logic [PW-1:0] PMAX = PW'(PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE, INIT_REQ, INIT_WAIT, WAIT_PERIOD, RD_REQ, RD_WAIT, PUBLISH, FAULT
    } state_t;

    state_t              state, state_n;
    logic [IW-1:0]       idx, idx_n;
    logic [RW-1:0]       retry, retry_n;
    logic [PW-1:0]       pcnt;
    logic [1:0]          bcnt;
    logic [7:0]          b0, b1, b0e, b1e;
    logic [N_CH-1:0][15:0] shadow;
    logic [23:0]         init_ent;
    logic [15:0]         ch_ent, rd_val;
    logic                ch_be, accept, got2, rd_good, round_start;

    // Table lookups as explicit muxes so idx width never has to match the tables
    always_comb begin
        init_ent = '0;
        ch_ent = '0;
        ch_be = 1'b0;
        for (int i = 0; i < N_INIT; i++)
            if (idx == IW'(i)) init_ent = INIT_TABLE[24*i +: 24];
        for (int i = 0; i < N_CH; i++)
            if (idx == IW'(i)) begin
                ch_ent = CH_TABLE[16*i +: 16];
                ch_be = CH_BE[i];
            end
    end

    // A byte arriving with txn_done is counted before completion is judged
    always_comb begin
        b0e = (bcnt == 2'd0 && rd_valid) ? rd_data : b0;
        b1e = (bcnt == 2'd1 && rd_valid) ? rd_data : b1;
        got2 = (bcnt == 2'd2) || (bcnt == 2'd1 && rd_valid);
        rd_good = got2 && !txn_nack;
        rd_val = ch_be ? {b0e, b1e} : {b1e, b0e};
        accept = txn_valid && txn_ready;
    end

    always_comb begin
        state_n = state;
        idx_n = idx;
        retry_n = retry;
        case (state)
            IDLE: if (enable) begin
                state_n = INIT_REQ;
                idx_n = '0;
                retry_n = '0;
            end
            INIT_REQ: begin
                if (accept) state_n = INIT_WAIT;
                else if (!enable) state_n = IDLE;
            end
            INIT_WAIT: if (txn_done) begin
                if (!enable) state_n = IDLE;
                else if (!txn_nack) begin
                    retry_n = '0;
                    if (idx == IW'(N_INIT - 1)) begin
                        idx_n = '0;
                        state_n = RD_REQ;
                    end else begin
                        idx_n = idx + IW'(1);
                        state_n = INIT_REQ;
                    end
                end else if (retry == RW'(MAX_RETRY)) state_n = FAULT;
                else begin
                    retry_n = retry + RW'(1);
                    state_n = INIT_REQ;
                end
            end
            RD_REQ: begin
                if (accept) state_n = RD_WAIT;
                else if (!enable) state_n = IDLE;
            end
            RD_WAIT: if (txn_done) begin
                if (!enable) state_n = IDLE;
                else if (rd_good) begin
                    retry_n = '0;
                    if (idx == IW'(N_CH - 1)) begin
                        idx_n = '0;
                        state_n = PUBLISH;
                    end else begin
                        idx_n = idx + IW'(1);
                        state_n = RD_REQ;
                    end
                end else if (retry == RW'(MAX_RETRY)) state_n = FAULT;
                else begin
                    retry_n = retry + RW'(1);
                    state_n = RD_REQ;
                end
            end
            // A late round has saturated pcnt at PMAX, so it restarts at once
            PUBLISH: begin
                if (!enable) state_n = IDLE;
                else if (pcnt == PMAX) state_n = RD_REQ;
                else state_n = WAIT_PERIOD;
            end
            WAIT_PERIOD: begin
                if (!enable) state_n = IDLE;
                else if (pcnt == PMAX) state_n = RD_REQ;
            end
            FAULT: state_n = FAULT;
            default: state_n = IDLE;
        endcase
        round_start = (state_n == RD_REQ) &&
                      (state == INIT_WAIT || state == WAIT_PERIOD || state == PUBLISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            retry <= '0;
            pcnt <= '0;
            bcnt <= '0;
            b0 <= '0;
            b1 <= '0;
            shadow <= '0;
            txn_valid <= 1'b0;
            txn_rw <= 1'b0;
            txn_slave <= '0;
            txn_reg <= '0;
            txn_wdata <= '0;
            ch_data <= '0;
            sample_valid <= 1'b0;
            sample_count <= '0;
            busy <= 1'b0;
            overrun <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            retry <= retry_n;
            txn_valid <= (state == INIT_REQ && state_n == INIT_REQ) ||
                         (state == RD_REQ && state_n == RD_REQ);
            if (state == INIT_REQ) begin
                txn_rw <= 1'b0;
                {txn_slave, txn_reg, txn_wdata} <= init_ent;
            end else if (state == RD_REQ) begin
                txn_rw <= 1'b1;
                {txn_slave, txn_reg} <= ch_ent;
            end
            if (state == RD_REQ) bcnt <= '0;
            else if (state == RD_WAIT && rd_valid && bcnt != 2'd2) begin
                if (bcnt == 2'd0) b0 <= rd_data;
                else b1 <= rd_data;
                bcnt <= bcnt + 2'd1;
            end
            for (int i = 0; i < N_CH; i++)
                if (state == RD_WAIT && txn_done && rd_good && idx == IW'(i))
                    shadow[i] <= rd_val;
            sample_valid <= (state_n == PUBLISH);
            if (state_n == PUBLISH) begin
                sample_count <= sample_count + 16'd1;
                for (int i = 0; i < N_CH; i++)
                    ch_data[16*i +: 16] <= (idx == IW'(i)) ? rd_val : shadow[i];
            end
            if (round_start) pcnt <= '0;
            else if (pcnt != PMAX) pcnt <= pcnt + PW'(1);
            overrun <= overrun | ((state == RD_REQ || state == RD_WAIT) && pcnt == PMAX);
            busy <= (state_n != IDLE);
            fault <= fault | (state_n == FAULT);
        end
    end
endmodule

// File: tb/tb_i2c_sensor_poller.sv
// Directed bench for i2c_sensor_poller: a scripted I2C engine replays
// expected-transaction tables and checks requests, snapshots and status flags.
module tb_i2c_sensor_poller;
    logic clk = 1'b0;
    logic rst, enable, txn_ready, rd_valid, txn_done, txn_nack;
    logic [7:0] rd_data;
    logic txn_valid, txn_rw, sample_valid, busy, overrun, fault;
    logic [7:0] txn_slave, txn_reg, txn_wdata;
    logic [95:0] ch_data;
    logic [15:0] sample_count;

    i2c_sensor_poller #(.PERIOD(200)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_rw(txn_rw),
        .txn_slave(txn_slave), .txn_reg(txn_reg), .txn_wdata(txn_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .txn_done(txn_done), .txn_nack(txn_nack),
        .ch_data(ch_data), .sample_valid(sample_valid), .sample_count(sample_count),
        .busy(busy), .overrun(overrun), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rw;
        logic [7:0] slave, rg, wdata;
        int nbytes;
        logic [7:0] b0, b1;
        bit nack;
    } vec_t;

    localparam logic [95:0] EXP_A = {16'h0102, 16'hABCD, 16'h3412, 16'hBC9A, 16'h7856, 16'h1234};
    localparam logic [95:0] EXP_R = {16'hF00F, 16'h9ABC, 16'h5678, 16'hADDE, 16'h4433, 16'h2211};

    int ncmp = 0, nerr = 0;
    int cyc = 0;
    int sv_n = 0;
    int sv_cyc[64];
    vec_t init_v[2], rd_v[6], rt_v[10];
    vec_t nk;
    int wc, n0, vcnt;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (sample_valid && sv_n < 64) begin
        sv_cyc[sv_n] = cyc;
        sv_n++;
    end

    function automatic vec_t mk(bit rw, logic [7:0] s, logic [7:0] r, logic [7:0] w,
                                int nb, logic [7:0] b0, logic [7:0] b1, bit nack);
        vec_t v;
        v.rw = rw; v.slave = s; v.rg = r; v.wdata = w;
        v.nbytes = nb; v.b0 = b0; v.b1 = b1; v.nack = nack;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait for one request, check it, accept it, then answer as the engine
    task automatic run_vec(input vec_t v, input int lat, input bit drop, output int wcnt);
        wcnt = 0;
        while (!txn_valid && wcnt < 2000) begin
            @(negedge clk);
            wcnt++;
        end
        if (!txn_valid) begin
            ncmp++;
            nerr++;
            $display("FAIL req_timeout: got no txn_valid expected request %0h/%0h", v.slave, v.rg);
            return;
        end
        if (v.rw) chk("req_read", {txn_rw, txn_slave, txn_reg}, {v.rw, v.slave, v.rg});
        else chk("req_write", {txn_rw, txn_slave, txn_reg, txn_wdata}, {v.rw, v.slave, v.rg, v.wdata});
        txn_ready = 1'b1;
        @(negedge clk);
        txn_ready = 1'b0;
        chk("valid_after_accept", txn_valid, 1'b0);
        if (drop) enable = 1'b0;
        repeat (lat) @(negedge clk);
        if (v.rw && v.nbytes > 0) begin
            for (int k = 0; k < v.nbytes; k++) begin
                rd_valid = 1'b1;
                rd_data = (k == 0) ? v.b0 : (k == 1) ? v.b1 : 8'hEE;
                if (k == v.nbytes - 1) begin
                    txn_done = 1'b1;
                    txn_nack = v.nack;
                end
                @(negedge clk);
            end
        end else begin
            txn_done = 1'b1;
            txn_nack = v.nack;
            @(negedge clk);
        end
        rd_valid = 1'b0;
        txn_done = 1'b0;
        txn_nack = 1'b0;
    endtask

    initial begin
        init_v[0] = mk(0, 8'h32, 8'h20, 8'h37, 0, 8'h00, 8'h00, 0);
        init_v[1] = mk(0, 8'h3C, 8'h02, 8'h00, 0, 8'h00, 8'h00, 0);
        rd_v[0] = mk(1, 8'h32, 8'hA8, 8'h00, 2, 8'h34, 8'h12, 0);
        rd_v[1] = mk(1, 8'h32, 8'hAA, 8'h00, 2, 8'h56, 8'h78, 0);
        rd_v[2] = mk(1, 8'h32, 8'hAC, 8'h00, 2, 8'h9A, 8'hBC, 0);
        rd_v[3] = mk(1, 8'h3C, 8'h03, 8'h00, 2, 8'h34, 8'h12, 0);
        rd_v[4] = mk(1, 8'h3C, 8'h07, 8'h00, 2, 8'hAB, 8'hCD, 0);
        rd_v[5] = mk(1, 8'h3C, 8'h05, 8'h00, 2, 8'h01, 8'h02, 0);
        rt_v[0] = mk(1, 8'h32, 8'hA8, 8'h00, 2, 8'h11, 8'h22, 0);
        rt_v[1] = mk(1, 8'h32, 8'hAA, 8'h00, 1, 8'h55, 8'h00, 0);
        rt_v[2] = mk(1, 8'h32, 8'hAA, 8'h00, 2, 8'h33, 8'h44, 0);
        rt_v[3] = mk(1, 8'h32, 8'hAC, 8'h00, 0, 8'h00, 8'h00, 1);
        rt_v[4] = mk(1, 8'h32, 8'hAC, 8'h00, 0, 8'h00, 8'h00, 1);
        rt_v[5] = mk(1, 8'h32, 8'hAC, 8'h00, 0, 8'h00, 8'h00, 1);
        rt_v[6] = mk(1, 8'h32, 8'hAC, 8'h00, 3, 8'hDE, 8'hAD, 0);
        rt_v[7] = mk(1, 8'h3C, 8'h03, 8'h00, 2, 8'h56, 8'h78, 0);
        rt_v[8] = mk(1, 8'h3C, 8'h07, 8'h00, 2, 8'h9A, 8'hBC, 0);
        rt_v[9] = mk(1, 8'h3C, 8'h05, 8'h00, 2, 8'hF0, 8'h0F, 0);
        nk = mk(1, 8'h32, 8'hAA, 8'h00, 0, 8'h00, 8'h00, 1);

        rst = 1'b1; enable = 1'b0; txn_ready = 1'b0; rd_valid = 1'b0;
        rd_data = 8'h00; txn_done = 1'b0; txn_nack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", txn_valid, 1'b0);
        chk("rst_fields", {txn_rw, txn_slave, txn_reg, txn_wdata}, 25'h0);
        chk("rst_ch_data", ch_data, 96'h0);
        chk("rst_flags", {sample_valid, busy, overrun, fault}, 4'h0);
        chk("rst_count", sample_count, 16'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // Round 1: init writes then six reads
        enable = 1'b1;
        for (int i = 0; i < 2; i++) run_vec(init_v[i], 2, 0, wc);
        for (int i = 0; i < 6; i++) run_vec(rd_v[i], 2, 0, wc);
        chk("r1_sample_valid", sample_valid, 1'b1);
        chk("r1_ch_data", ch_data, EXP_A);
        chk("r1_count", sample_count, 16'd1);
        @(negedge clk);
        chk("r1_pulse_width", sample_valid, 1'b0);

        // Rounds 2..5: exact PERIOD spacing
        for (int r = 2; r <= 5; r++)
            for (int i = 0; i < 6; i++) run_vec(rd_v[i], 2, 0, wc);
        @(negedge clk);
        chk("pulses_5", sv_n, 5);
        for (int i = 0; i < 4; i++) chk("period_spacing", sv_cyc[i+1] - sv_cyc[i], 200);
        chk("no_overrun", overrun, 1'b0);
        chk("count_5", sample_count, 16'd5);

        // Retries: short read, three NACKs, extra ignored byte
        for (int i = 0; i < 10; i++) run_vec(rt_v[i], 2, 0, wc);
        chk("retry_ch_data", ch_data, EXP_R);
        chk("retry_no_fault", fault, 1'b0);
        chk("retry_count", sample_count, 16'd6);

        // Slow engine: round longer than PERIOD
        for (int i = 0; i < 6; i++) run_vec(rd_v[i], 40, 0, wc);
        chk("overrun_set", overrun, 1'b1);
        chk("slow_count", sample_count, 16'd7);
        chk("slow_ch_data", ch_data, EXP_A);
        for (int i = 0; i < 6; i++) begin
            run_vec(rd_v[i], 40, 0, wc);
            if (i == 0) chk("back_to_back_start", wc, 2);
        end
        chk("slow_count2", sample_count, 16'd8);

        // Drop enable during the ch4 read
        for (int i = 0; i < 5; i++) run_vec(rd_v[i], 2, i == 4, wc);
        chk("drop_busy", busy, 1'b0);
        chk("drop_valid", {txn_valid, sample_valid}, 2'b00);
        n0 = sv_n;
        repeat (250) @(negedge clk);
        chk("drop_no_publish", sv_n, n0);
        chk("drop_count", sample_count, 16'd8);

        // Re-enable re-runs init; reset lands in INIT_WAIT of the second write
        enable = 1'b1;
        run_vec(init_v[0], 2, 0, wc);
        wc = 0;
        while (!txn_valid && wc < 2000) begin
            @(negedge clk);
            wc++;
        end
        chk("reinit_req2", {txn_rw, txn_slave, txn_reg, txn_wdata}, {1'b0, 24'h3C0200});
        txn_ready = 1'b1;
        @(negedge clk);
        txn_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", txn_valid, 1'b0);
        chk("mid_rst_flags", {sample_valid, busy, overrun, fault}, 4'h0);
        chk("mid_rst_data", ch_data, 96'h0);
        chk("mid_rst_count", sample_count, 16'h0);
        rst = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        txn_done = 1'b1;
        @(negedge clk);
        txn_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("late_done_ignored", {busy, txn_valid}, 2'b00);

        // Four NACKs on ch1 exhaust retries
        enable = 1'b1;
        for (int i = 0; i < 2; i++) run_vec(init_v[i], 2, 0, wc);
        run_vec(rd_v[0], 2, 0, wc);
        for (int i = 0; i < 4; i++) run_vec(nk, 2, 0, wc);
        chk("fault_set", {fault, busy}, 2'b11);
        vcnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (txn_valid) vcnt++;
        end
        chk("fault_no_requests", vcnt, 0);
        chk("fault_count", sample_count, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
